// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that allocates ids at issue, collects CDB results, retires in order and flushes on
// a retiring mispredicted branch. Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to the lookups.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd_in,
  output logic                      issue_ready,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [4:0]                issue_rd,
  input  logic                      wb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]               wb_value,
  input  logic                      wb_mispredict,
  input  logic [31:0]               wb_target,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
  output logic [31:0]               get_value1,
  output logic [31:0]               get_value2,
  output logic                      get_ready1,
  output logic                      get_ready2,
  output logic                      flush,
  output logic [31:0]               redirect_pc
);
  localparam int N = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ZERO = {ROB_SIZE_WIDTH{1'b0}};
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE  = PTR_ZERO + 1'b1;
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ZERO = {(ROB_SIZE_WIDTH+1){1'b0}};
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE  = CNT_ZERO + 1'b1;
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_FULL = CNT_ONE << ROB_SIZE_WIDTH;

  logic                      r_busy    [0:N-1];
  logic                      r_ready   [0:N-1];
  logic [4:0]                r_rd      [0:N-1];
  logic [31:0]               r_value   [0:N-1];
  logic                      r_mispred [0:N-1];
  logic [31:0]               r_target  [0:N-1];
  logic [ROB_SIZE_WIDTH-1:0] r_head;
  logic [ROB_SIZE_WIDTH-1:0] r_tail;
  logic [ROB_SIZE_WIDTH:0]   r_count;
  logic                      r_flush;
  logic [31:0]               r_redirect_pc;

  logic w_full;
  logic w_issue;
  logic w_wb;
  logic w_commit;
  logic w_flush_now;
  logic w_byp1;
  logic w_byp2;

  // Fullness is judged on the registered count, so a same-cycle retire never frees a slot for issue.
  assign w_full      = (r_count == CNT_FULL);
  assign issue_ready = rdy && !w_full;
  assign w_issue     = issue_valid && issue_ready;
  assign issue_rob_id = r_tail;
  assign issue_rd    = w_issue ? issue_rd_in : 5'd0;

  assign w_wb        = wb_valid && r_busy[wb_rob_id];
  assign w_commit    = rdy && r_busy[r_head] && r_ready[r_head];
  assign w_flush_now = w_commit && r_mispred[r_head];

  assign commit_rob_id = w_commit ? r_head : PTR_ZERO;
  assign commit_rd     = w_commit ? r_rd[r_head] : 5'd0;
  assign commit_value  = w_commit ? r_value[r_head] : 32'd0;

`ifdef ROB_WB_BYPASS_EN
  assign w_byp1 = w_wb && (ask_rob_id1 == wb_rob_id);
  assign w_byp2 = w_wb && (ask_rob_id2 == wb_rob_id);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign get_ready1 = w_byp1 || (r_busy[ask_rob_id1] && r_ready[ask_rob_id1]);
  assign get_ready2 = w_byp2 || (r_busy[ask_rob_id2] && r_ready[ask_rob_id2]);
  assign get_value1 = w_byp1 ? wb_value : r_value[ask_rob_id1];
  assign get_value2 = w_byp2 ? wb_value : r_value[ask_rob_id2];

  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;

  // Entry state, pointers and flush pulse; a retiring mispredict discards everything including same-cycle issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_busy[i]    <= 1'b0;
        r_ready[i]   <= 1'b0;
        r_rd[i]      <= 5'd0;
        r_value[i]   <= 32'd0;
        r_mispred[i] <= 1'b0;
        r_target[i]  <= 32'd0;
      end
      r_head        <= PTR_ZERO;
      r_tail        <= PTR_ZERO;
      r_count       <= CNT_ZERO;
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else if (rdy) begin
      if (w_flush_now) begin
        for (int i = 0; i < N; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
        r_head        <= PTR_ZERO;
        r_tail        <= PTR_ZERO;
        r_count       <= CNT_ZERO;
        r_flush       <= 1'b1;
        r_redirect_pc <= r_target[r_head];
      end else begin
        r_flush <= 1'b0;
        if (w_wb) begin
          r_ready[wb_rob_id]   <= 1'b1;
          r_value[wb_rob_id]   <= wb_value;
          r_mispred[wb_rob_id] <= wb_mispredict;
          r_target[wb_rob_id]  <= wb_target;
        end
        if (w_issue) begin
          r_busy[r_tail]    <= 1'b1;
          r_ready[r_tail]   <= 1'b0;
          r_rd[r_tail]      <= issue_rd_in;
          r_mispred[r_tail] <= 1'b0;
          r_tail            <= r_tail + PTR_ONE;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + PTR_ONE;
        end
        if (w_issue && !w_commit) begin
          r_count <= r_count + CNT_ONE;
        end else if (!w_issue && w_commit) begin
          r_count <= r_count - CNT_ONE;
        end else begin
          r_count <= r_count;
        end
      end
    end else begin
      r_flush <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic, checked against a queue-based model of
// in-order retirement where each in-flight instruction is one queue element.
module tb_reorder_buffer;
  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         issue_valid;
  logic [4:0]   issue_rd_in;
  logic         issue_ready;
  logic [W-1:0] issue_rob_id;
  logic [4:0]   issue_rd;
  logic         wb_valid;
  logic [W-1:0] wb_rob_id;
  logic [31:0]  wb_value;
  logic         wb_mispredict;
  logic [31:0]  wb_target;
  logic [W-1:0] commit_rob_id;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_value;
  logic [W-1:0] ask_rob_id1;
  logic [W-1:0] ask_rob_id2;
  logic [31:0]  get_value1;
  logic [31:0]  get_value2;
  logic         get_ready1;
  logic         get_ready2;
  logic         flush;
  logic [31:0]  redirect_pc;

  reorder_buffer #(.ROB_SIZE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd_in(issue_rd_in), .issue_ready(issue_ready),
    .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
    .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
    .get_value1(get_value1), .get_value2(get_value2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] value;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          next_id;
  bit          m_flush;
  logic [31:0] m_redirect;
  int          n_vec;
  int          n_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int find(input int id);
    foreach (q[i]) if (q[i].id == id) return i;
    return -1;
  endfunction

  task automatic lookup_exp(input int a, input bit wv, input int wid, input logic [31:0] wval,
                            output bit gr, output logic [31:0] gv);
    int f;
    f  = find(a);
    gr = (f >= 0) && q[f].done;
    gv = (f >= 0) ? q[f].value : 32'd0;
`ifdef ROB_WB_BYPASS_EN
    if (wv && find(wid) >= 0 && a == wid) begin
      gr = 1'b1;
      gv = wval;
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_rd_in = 5'd0; wb_valid = 1'b0;
    wb_rob_id = 3'd0; wb_value = 32'd0; wb_mispredict = 1'b0; wb_target = 32'd0;
    ask_rob_id1 = 3'd0; ask_rob_id2 = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    next_id = 0; m_flush = 1'b0; m_redirect = 32'd0;
  endtask

  task automatic step(input bit i_rdy, input bit iv, input logic [4:0] ird, input bit wv, input int wid,
                      input logic [31:0] wval, input bit wmis, input logic [31:0] wtgt, input int a1, input int a2);
    bit e_ready, e_issue, e_commit, gr;
    logic [31:0] gv;
    int widx;
    ent_t e;
    @(negedge clk);
    rdy = i_rdy; issue_valid = iv; issue_rd_in = ird; wb_valid = wv; wb_rob_id = 3'(wid);
    wb_value = wval; wb_mispredict = wmis; wb_target = wtgt; ask_rob_id1 = 3'(a1); ask_rob_id2 = 3'(a2);
    #1;
    e_ready  = i_rdy && (q.size() < N);
    e_issue  = iv && e_ready;
    e_commit = i_rdy && (q.size() > 0) && q[0].done;
    chk("issue_ready", 32'(issue_ready), 32'(e_ready));
    chk("issue_rob_id", 32'(issue_rob_id), 32'(next_id));
    chk("issue_rd", 32'(issue_rd), e_issue ? 32'(ird) : 32'd0);
    if (e_commit) begin
      chk("commit_rd", 32'(commit_rd), 32'(q[0].rd));
      chk("commit_value", commit_value, q[0].value);
      chk("commit_rob_id", 32'(commit_rob_id), 32'(q[0].id));
    end else begin
      chk("commit_rd_idle", 32'(commit_rd), 32'd0);
    end
    chk("flush", 32'(flush), 32'(m_flush));
    chk("redirect_pc", redirect_pc, m_redirect);
    lookup_exp(a1, wv, wid, wval, gr, gv);
    chk("get_ready1", 32'(get_ready1), 32'(gr));
    if (gr) chk("get_value1", get_value1, gv);
    lookup_exp(a2, wv, wid, wval, gr, gv);
    chk("get_ready2", 32'(get_ready2), 32'(gr));
    if (gr) chk("get_value2", get_value2, gv);
    @(posedge clk);
    if (i_rdy) begin
      if (e_commit && q[0].mis) begin
        m_redirect = q[0].tgt;
        m_flush    = 1'b1;
        q.delete();
        next_id = 0;
      end else begin
        m_flush = 1'b0;
        widx = find(wid);
        if (wv && widx >= 0) begin
          q[widx].done  = 1'b1;
          q[widx].value = wval;
          q[widx].mis   = wmis;
          q[widx].tgt   = wtgt;
        end
        if (e_commit) void'(q.pop_front());
        if (e_issue) begin
          e.id = next_id; e.rd = ird; e.done = 1'b0; e.value = 32'd0; e.mis = 1'b0; e.tgt = 32'd0;
          q.push_back(e);
          next_id = (next_id + 1) % N;
        end
      end
    end else begin
      m_flush = 1'b0;
    end
  endtask

  task automatic idle(input int a1, input int a2);
    step(1'b1, 1'b0, 5'd0, 1'b0, 0, 32'd0, 1'b0, 32'd0, a1, a2);
  endtask

  task automatic issue(input logic [4:0] rd);
    step(1'b1, 1'b1, rd, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 1);
  endtask

  task automatic wb(input int id, input logic [31:0] val, input bit mis, input logic [31:0] tgt);
    step(1'b1, 1'b0, 5'd0, 1'b1, id, val, mis, tgt, id, 0);
  endtask

  initial begin
    bit iv, wv, rr;
    int wid;
    n_vec = 0; n_miss = 0;
    do_reset();

    // Basic issue, writeback and in-order retire.
    idle(0, 1);
    issue(5'd5);
    issue(5'd7);
    wb(0, 32'h1234, 1'b0, 32'd0);
    idle(0, 1);
    idle(1, 0);

    // Fill to capacity, attempt a ninth issue, then retire and refill.
    do_reset();
    for (int i = 0; i < N; i++) issue(5'(i + 1));
    issue(5'd9);
    step(1'b1, 1'b1, 5'd10, 1'b1, 0, 32'hAAAA, 1'b0, 32'd0, 0, 7);
    step(1'b1, 1'b1, 5'd11, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 7);
    issue(5'd12);
    issue(5'd13);

    // Out-of-order writebacks retire in order.
    do_reset();
    for (int i = 0; i < 3; i++) issue(5'(i + 20));
    wb(2, 32'h22, 1'b0, 32'd0);
    wb(0, 32'h00, 1'b0, 32'd0);
    wb(1, 32'h11, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) idle(i, 2);

    // Mispredicted branch: flush pulse, redirect, ids restart from zero.
    do_reset();
    issue(5'd1);
    issue(5'd0);
    issue(5'd3);
    wb(0, 32'h55, 1'b0, 32'd0);
    wb(1, 32'h66, 1'b1, 32'h100);
    step(1'b1, 1'b1, 5'd4, 1'b0, 0, 32'd0, 1'b0, 32'd0, 1, 2);
    idle(0, 1);
    idle(0, 1);

    // Freeze right after a flush pulse and reset overriding a pending flush.
    issue(5'd2);
    wb(0, 32'h77, 1'b1, 32'h200);
    step(1'b1, 1'b0, 5'd0, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 0);
    step(1'b0, 1'b1, 5'd6, 1'b0, 0, 32'd0, 1'b0, 32'd0, 0, 0);
    issue(5'd2);
    wb(0, 32'h88, 1'b1, 32'h300);
    do_reset();
    idle(0, 0);

    // Lookup of an entry while it is being written back.
    for (int i = 0; i < 4; i++) issue(5'(i + 1));
    step(1'b1, 1'b0, 5'd0, 1'b1, 3, 32'hBEEF, 1'b0, 32'd0, 3, 3);
    idle(3, 3);

    // Randomized traffic with occasional freezes, mispredicts and resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      rr = ($urandom_range(0, 7) != 0);
      iv = ($urandom_range(0, 2) != 0);
      wv = ($urandom_range(0, 1) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wid = q[$urandom_range(0, q.size() - 1)].id;
      else wid = int'($urandom_range(0, N - 1));
      step(rr, iv, 5'($urandom_range(0, 31)), wv, wid, $urandom, ($urandom_range(0, 19) == 0), $urandom,
           int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
